// File: rtl/flappy_game_ctrl_if.sv
// Bundle between the game controller and the stdin/view blocks.
// master = controller side, slave = io/view side.
interface flappy_game_ctrl_if;
    logic [7:0]  inp;
    logic [1:0]  scene;
    logic [8:0]  bird;
    logic [71:0] gaps;
    logic [7:0]  score;
    logic [7:0]  hiscore;

    modport master (
        input  inp,
        output scene, bird, gaps, score, hiscore
    );

    modport slave (
        output inp,
        input  scene, bird, gaps, score, hiscore
    );
endinterface

// File: rtl/flappy_game_ctrl.sv
// Flappy game sequencer: scene FSM, physics tick, pipes, collisions, score.
// Define FLAPPY_HISCORE_EN to keep a best-score register on io.hiscore.
module flappy_game_ctrl #(
    parameter int HEIGHT   = 40,
    parameter int WIDTH    = 80,
    parameter int TICK_DIV = 4,
    parameter int FLAP_VEL = 3,
    parameter int GAP_SIZE = 10
) (
    input logic clk,
    input logic rst,
    flappy_game_ctrl_if.master io
);
    localparam int TW = $clog2(TICK_DIV);
    localparam logic [71:0] GAPS_INIT =
        72'h141E14_28190F_3C2319;
    localparam logic signed [8:0] TOP = 9'(HEIGHT - 1);

    typedef enum logic [1:0] {
        SPLASH, PLAYING, GAMEOVER, ILLEGAL
    } scene_e;

    typedef struct packed {
        logic [7:0] pos;
        logic [7:0] mx;
        logic [7:0] mn;
    } pipe_t;

    scene_e            scene_q, scene_d;
    logic [7:0]        alt_q, alt_d;
    logic signed [3:0] vel_q, vel_d;
    logic              flap_q, flap_d;
    logic              req_q, req_d;
    logic [7:0]        score_q, score_d;
    logic [7:0]        lfsr_q, lfsr_d;
    logic [TW-1:0]     tick_q, tick_d;
    pipe_t [2:0]       pipes_q, pipes_d, pipes_t;

    logic              space, quit, tick;
    logic              flap_eff, ground, hit;
    logic signed [3:0] vel_t;
    logic signed [8:0] alt_s, alt_c;
    logic [4:0]        r;
    logic [7:0]        spawn_mn;
    logic [1:0]        pass_cnt;
    logic [9:0]        score_sum;
    logic [7:0]        score_t;

    // Candidate tick results; only committed on a tick in PLAYING.
    always_comb begin
        space    = io.inp == 8'd32;
        quit     = io.inp == 8'd120;
        tick     = tick_q == TW'(TICK_DIV - 1);
        flap_eff = req_q | space;
        if (flap_eff)
            vel_t = 4'(FLAP_VEL);
        else if (vel_q > -4'sd3)
            vel_t = vel_q - 4'sd1;
        else
            vel_t = -4'sd3;
        alt_s = $signed({1'b0, alt_q})
              + $signed({{5{vel_t[3]}}, vel_t});
        alt_c  = (alt_s > TOP) ? TOP : alt_s;
        ground = alt_c <= 9'sd0;
        r = lfsr_q[4:0];
        spawn_mn = 8'd4 + ((r < 5'd24) ? {3'b0, r}
                                       : {3'b0, r} - 8'd16);
        pass_cnt = '0;
        hit      = 1'b0;
        pipes_t  = pipes_q;
        for (int i = 0; i < 3; i++) begin
            if (pipes_q[i].pos == 8'd0) begin
                pipes_t[i].pos = 8'(WIDTH - 1);
                pipes_t[i].mn  = spawn_mn;
                pipes_t[i].mx  = spawn_mn + 8'(GAP_SIZE);
            end else begin
                pipes_t[i].pos = pipes_q[i].pos - 8'd1;
            end
            if (pipes_q[i].pos == 8'd2)
                pass_cnt = pass_cnt + 2'd1;
            if (pipes_t[i].pos <= 8'd8 &&
                (alt_c >= $signed({1'b0, pipes_t[i].mx}) ||
                 alt_c <= $signed({1'b0, pipes_t[i].mn})))
                hit = 1'b1;
        end
        score_sum = {2'b0, score_q} + {8'b0, pass_cnt};
        score_t = (score_sum > 10'd255) ? 8'hFF
                                        : score_sum[7:0];
    end

    always_comb begin
        scene_d = scene_q;
        alt_d   = alt_q;
        vel_d   = vel_q;
        flap_d  = flap_q;
        req_d   = req_q;
        score_d = score_q;
        tick_d  = tick_q;
        pipes_d = pipes_q;
        lfsr_d  = {lfsr_q[6:0],
                   lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        unique case (scene_q)
            SPLASH: begin
                if (space) begin
                    scene_d = PLAYING;
                    alt_d   = 8'd20;
                    vel_d   = '0;
                    req_d   = 1'b0;
                    score_d = '0;
                    tick_d  = '0;
                    pipes_d = GAPS_INIT;
                end
            end
            PLAYING: begin
                if (quit) begin
                    scene_d = GAMEOVER;
                    flap_d  = 1'b0;
                end else if (tick) begin
                    tick_d  = '0;
                    vel_d   = vel_t;
                    req_d   = 1'b0;
                    pipes_d = pipes_t;
                    score_d = score_t;
                    alt_d   = ground ? 8'd0 : alt_c[7:0];
                    if (ground || hit) begin
                        scene_d = GAMEOVER;
                        flap_d  = 1'b0;
                    end else begin
                        flap_d = flap_eff;
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                    req_d  = flap_eff;
                end
            end
            GAMEOVER: begin
                flap_d = 1'b0;
                if (space)
                    scene_d = SPLASH;
            end
            default: scene_d = SPLASH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scene_q <= SPLASH;
            alt_q   <= 8'd20;
            vel_q   <= '0;
            flap_q  <= 1'b0;
            req_q   <= 1'b0;
            score_q <= '0;
            tick_q  <= '0;
            lfsr_q  <= 8'hA5;
            pipes_q <= GAPS_INIT;
        end else begin
            scene_q <= scene_d;
            alt_q   <= alt_d;
            vel_q   <= vel_d;
            flap_q  <= flap_d;
            req_q   <= req_d;
            score_q <= score_d;
            tick_q  <= tick_d;
            lfsr_q  <= lfsr_d;
            pipes_q <= pipes_d;
        end
    end

`ifdef FLAPPY_HISCORE_EN
    logic [7:0] hi_q;

    // Updated on the edge that ends a run, so it sees the final score.
    always_ff @(posedge clk) begin
        if (rst)
            hi_q <= '0;
        else if (scene_q == PLAYING &&
                 scene_d == GAMEOVER &&
                 score_d > hi_q)
            hi_q <= score_d;
    end

    assign io.hiscore = hi_q;
`else
    assign io.hiscore = '0;
`endif

    assign io.scene = scene_q;
    assign io.bird  = {alt_q, flap_q};
    assign io.gaps  = pipes_q;
    assign io.score = score_q;
endmodule
